// File: rtl/seg7_pkg.sv
// Shared constants for the 3-digit multiplexed 7-segment scan driver:
// hex glyph table, digit-pointer encodings and the segment "off" pattern.
package seg7_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D0   = 2'd1,
        D1   = 2'd2,
        D2   = 2'd3
    } digit_t;

    // Active-high {a,b,c,d,e,f,g}; entry 15 listed first.
    localparam logic [15:0][6:0] HEX7 = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble to active-high 7-segment glyph; polarity is the parent's job.
module hex7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    assign pat = HEX7[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Three-digit hex scanner: own prescaler, IDLE->D0->D1->D2 pointer, per-frame
// snapshot, leading-zero blanking and a page-selected decimal point.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV       = 250000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        CLK_RAW,
    input  logic        reset,
    input  logic [11:0] value,
    input  logic [1:0]  page,
    output logic [6:0]  seg,
    output logic [2:0]  se,
    output logic        dot,
    output logic        frame_start
);

    localparam int             CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [6:0]     SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [2:0]     EN_POL  = {3{EN_ACTIVE_LOW}};

    logic [CW-1:0] cnt;
    logic          tick;
    digit_t        state, nxt;
    logic [11:0]   snap, frame;

    logic [NUM_DIGITS-1:0][6:0] pat;
    logic [NUM_DIGITS-1:0]      blank;

    logic [6:0] seg_n;
    logic [2:0] se_n;
    logic       dot_n;

    assign tick = (cnt == CNT_MAX);

    always_comb begin
        nxt = D0;
        case (state)
            IDLE:    nxt = D0;
            D0:      nxt = D1;
            D1:      nxt = D2;
            default: nxt = D0;
        endcase
    end

    // D0 shows the live value, which is exactly what gets snapshotted on that edge.
    assign frame = (nxt == D0) ? value : snap;

    generate
        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
            hex7_decode u_dec (
                .nib (frame[4*d +: 4]),
                .pat (pat[d])
            );
        end
    endgenerate

    assign blank[0] = 1'b0;
    assign blank[1] = BLANK_LZ && (frame[11:4] == 8'h00);
    assign blank[2] = BLANK_LZ && (frame[11:8] == 4'h0);

    always_comb begin
        seg_n = SEG_OFF;
        se_n  = 3'b000;
        dot_n = 1'b0;
        case (nxt)
            D0: begin
                dot_n = (page == 2'd0);
                seg_n = pat[0];
                se_n  = 3'b001;
            end
            D1: begin
                dot_n = (page == 2'd1);
                seg_n = blank[1] ? SEG_OFF : pat[1];
                se_n  = (blank[1] && !dot_n) ? 3'b000 : 3'b010;
            end
            D2: begin
                dot_n = (page == 2'd2);
                seg_n = blank[2] ? SEG_OFF : pat[2];
                se_n  = (blank[2] && !dot_n) ? 3'b000 : 3'b100;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_RAW) begin
        if (reset) begin
            cnt         <= '0;
            state       <= IDLE;
            snap        <= '0;
            seg         <= SEG_OFF ^ SEG_POL;
            se          <= EN_POL;
            dot         <= SEG_ACTIVE_LOW;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            frame_start <= tick && (nxt == D0);
            if (tick) begin
                state <= nxt;
                if (nxt == D0)
                    snap <= value;
                seg <= seg_n ^ SEG_POL;
                se  <= se_n ^ EN_POL;
                dot <= dot_n ^ SEG_ACTIVE_LOW;
            end
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the board top's 12-bit display slice and 2-bit page select.
- Time-multiplexes three hex digits onto one common 7-segment bus (a..g) with three digit enables (SE0..SE2) and a decimal point.
- Owns its own scan prescaler from CLK_RAW, so the top no longer needs a separate divided display clock.
- Snapshots the value once per frame so the display never tears mid-scan.

Parameters:
- TICK_DIV, 250000: CLK_RAW cycles per digit slot; range 2..2^26-1.
- SEG_ACTIVE_LOW, 1: 1 = segments and dot are driven low-true; 0 = high-true.
- EN_ACTIVE_LOW, 1: 1 = SE0..SE2 are low-true; 0 = high-true.
- BLANK_LZ, 1: 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- CLK_RAW  in  1  board clock; the only clock.
- reset  in  1  synchronous, active-high.
- value  in  12  three hex nibbles; digit0 = [3:0], digit1 = [7:4], digit2 = [11:8].
- page  in  2  selected page 0..2; 3 is invalid.
- seg  out  7  {a,b,c,d,e,f,g}, registered.
- se  out  3  {SE2,SE1,SE0} digit enables, registered, one-hot or all-off.
- dot  out  1  decimal point, registered.
- frame_start  out  1  one-cycle pulse on each edge where digit 0 is driven.

Behaviour:
- Interface: one clock (CLK_RAW); reset is synchronous and active-high, sampled on the rising CLK_RAW edge.
- Reset values:
  - prescaler cnt = 0; digit pointer = IDLE; snapshot = 0.
  - seg = all off and dot = off (polarity-applied); se = all off; frame_start = 0.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted while cnt == TICK_DIV-1.
  - Reset mid-count returns cnt to 0 immediately.
- Digit pointer FSM: states IDLE, D0, D1, D2. On tick: IDLE->D0, D0->D1, D1->D2, D2->D0. There is no path back to IDLE except reset.
- Snapshot: on any tick whose next state is D0, snapshot <= value. Slots D1 and D2 use the snapshot.
- Output timing: seg, se, dot and frame_start update on the same edge as the pointer transition, decoded from the next state.
  - Slot D0 decodes value directly.
  - Slots D1 and D2 decode the snapshot.
  - Outputs hold between ticks.
  - After reset release, the first drive happens at edge TICK_DIV (counting the first post-reset edge as 1).
- Hex decode, active-high {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Invert the whole vector when SEG_ACTIVE_LOW=1.
- Leading-zero blanking (BLANK_LZ=1), evaluated on the frame's data:
  - digit2 is blank if nibble2 == 0.
  - digit1 is blank if nibble2 == 0 and nibble1 == 0.
  - A blank slot drives seg off and se all off.
- Dot:
  - Lit in the slot whose index equals page.
  - If that slot is blanked, se for that slot is still asserted, with seg off and only the dot lit.
  - page == 3: dot never lit.
  - page is sampled at each tick; it is not snapshotted.
- frame_start = 1 for exactly the one cycle following the edge entering D0; 0 otherwise.
- value changing mid-frame: D1 and D2 keep showing the snapshot; the change appears at the next D0.
- Polarity: se and dot follow EN_ACTIVE_LOW and SEG_ACTIVE_LOW respectively. "Off" means the inactive level.

Decomposition:
- Shared package seg7_pkg:
  - HEX7 16-entry constant table (active-high).
  - Digit state encodings IDLE/D0/D1/D2.
  - SEG_OFF constant.
- One sub-module hex7_decode: combinational, 4-bit nibble in -> 7-bit active-high pattern out. The parent applies polarity.

Test Plan:
- Reset/first drive (TICK_DIV=4, both polarities 0): hold reset 3 cycles, release.
  - -> seg = 0000000, se = 000 for edges 1-3.
  - -> at edge 4, se = 001, frame_start = 1 for one cycle.
- Scan order (value=12'hA5F, BLANK_LZ=0, page=0):
  - -> slots in order: seg 1000111/se 001/dot 1; seg 1011011/se 010/dot 0; seg 1110111/se 100/dot 0.
  - -> then repeats, with frame_start every 12 cycles.
- Tearing guard: value=12'h123; change to 12'h456 one cycle after entering D0.
  - -> D1 shows 2 (1101101), D2 shows 1 (0110000).
  - -> next D0 shows 6 (1011111).
- Leading-zero blanking (BLANK_LZ=1, value=12'h007, page=2):
  - -> D0: seg 1110000, se 001.
  - -> D1: se 000.
  - -> D2: se 100, seg 0000000, dot 1.
  - -> with page=3, D2 gives se 000 and dot 0.
- Polarity (SEG_ACTIVE_LOW=1, EN_ACTIVE_LOW=1, value=12'h000):
  - -> during reset, seg = 1111111, se = 111, dot = 1.
  - -> D0 drives seg 0000001, se 110.
- Reset mid-operation: assert reset for 1 cycle while in D2 with cnt=2.
  - -> next edge: outputs off, cnt = 0.
  - -> D0 is re-entered exactly 4 edges after reset release.
